// File: rtl/oversampled_demodulator.sv
// Oversampled serial receiver: recovers symbol timing from line transitions, hunts for a
// sync word, then deserializes a fixed number of code words per frame.
module oversampled_demodulator #(
  parameter int unsigned           OSR         = 8,
  parameter int unsigned           WORD_W      = 7,
  parameter int unsigned           SYNC_W      = 8,
  parameter logic [SYNC_W-1:0]     SYNC_WORD   = 8'hE4,
  parameter int unsigned           FRAME_WORDS = 4,
  parameter int unsigned           RUN_LIMIT   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_i,
  output logic [WORD_W-1:0] data_o,
  output logic              valid_o,
  output logic              locked_o,
  output logic              err_o
);

  localparam int unsigned PhW    = $clog2(OSR);
  localparam int unsigned RunMax = RUN_LIMIT * OSR;
  localparam int unsigned RunW   = $clog2(RunMax + 1);
  localparam int unsigned BitW   = $clog2(WORD_W + 1);
  localparam int unsigned WcntW  = $clog2(FRAME_WORDS + 1);

  localparam logic [PhW-1:0]   SamplePh = PhW'(OSR / 2 + 1);
  localparam logic [PhW-1:0]   LastPh   = PhW'(OSR - 1);
  localparam logic [RunW-1:0]  RunLast  = RunW'(RunMax - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(WORD_W - 1);
  localparam logic [WcntW-1:0] WordLast = WcntW'(FRAME_WORDS - 1);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  // Line conditioning and symbol timing
  logic           sync1_q;
  logic           s_q;
  logic [1:0]     smp_q;     // smp_q[0] is s delayed one cycle
  logic [PhW-1:0] ph_q;
  logic [PhW-1:0] cur_ph;
  logic           edge_det;
  logic           maj;
  logic           bit_q;
  logic           bit_stb_q;

  assign edge_det = s_q ^ smp_q[0];
  assign cur_ph   = edge_det ? '0 : ph_q;
  assign maj      = (smp_q[1] & smp_q[0]) | (smp_q[1] & s_q) | (smp_q[0] & s_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b0;
      s_q       <= 1'b0;
      smp_q     <= '0;
      ph_q      <= '0;
      bit_q     <= 1'b0;
      bit_stb_q <= 1'b0;
    end else begin
      sync1_q <= data_i;
      s_q     <= sync1_q;
      smp_q   <= {smp_q[0], s_q};
      // The edge cycle itself is phase 0, so the counter resumes at 1.
      if (edge_det) begin
        ph_q <= PhW'(1);
      end else if (ph_q == LastPh) begin
        ph_q <= '0;
      end else begin
        ph_q <= ph_q + 1'b1;
      end
      bit_stb_q <= (cur_ph == SamplePh);
      bit_q     <= maj;
    end
  end

  // Framing
  state_e            state_q;
  logic [SYNC_W-1:0] sync_sr_q;
  logic [SYNC_W-1:0] sync_next;
  logic [WORD_W-1:0] word_sr_q;
  logic [WORD_W-1:0] word_next;
  logic [BitW-1:0]   bit_cnt_q;
  logic [WcntW-1:0]  word_cnt_q;
  logic [RunW-1:0]   run_cnt_q;
  logic              timeout;
  logic              word_done;
  logic              frame_done;

  assign sync_next  = SYNC_W'({sync_sr_q, bit_q});
  assign word_next  = WORD_W'({word_sr_q, bit_q});
  assign timeout    = (state_q == StLocked) && !edge_det && (run_cnt_q == RunLast);
  assign word_done  = bit_stb_q && (bit_cnt_q == BitLast);
  assign frame_done = (word_cnt_q == WordLast);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StHunt;
      sync_sr_q  <= '0;
      word_sr_q  <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      run_cnt_q  <= '0;
      data_o     <= '0;
      valid_o    <= 1'b0;
      locked_o   <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      valid_o  <= 1'b0;
      err_o    <= 1'b0;
      locked_o <= (state_q == StLocked);
      unique case (state_q)
        StHunt: begin
          if (bit_stb_q) begin
            sync_sr_q <= sync_next;
            if (sync_next == SYNC_WORD) begin
              state_q    <= StLocked;
              word_sr_q  <= '0;
              bit_cnt_q  <= '0;
              word_cnt_q <= '0;
              run_cnt_q  <= '0;
            end
          end
        end
        StLocked: begin
          run_cnt_q <= edge_det ? '0 : run_cnt_q + 1'b1;
          // A timeout beats a word completing in the same cycle.
          if (timeout) begin
            err_o      <= 1'b1;
            state_q    <= StHunt;
            sync_sr_q  <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            run_cnt_q  <= '0;
          end else if (bit_stb_q) begin
            word_sr_q <= word_next;
            if (word_done) begin
              data_o    <= word_next;
              valid_o   <= 1'b1;
              bit_cnt_q <= '0;
              if (frame_done) begin
                state_q    <= StHunt;
                sync_sr_q  <= '0;
                word_cnt_q <= '0;
                run_cnt_q  <= '0;
              end else begin
                word_cnt_q <= word_cnt_q + 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StHunt;
      endcase
    end
  end

endmodule

// File: tb/tb_oversampled_demodulator.sv
// Self-checking bench for oversampled_demodulator: table-driven frames plus hand-written
// reset, timeout and reset-mid-frame sequences, with a scoreboard of expected words.
module tb_oversampled_demodulator;

  localparam int OSR = 8;

  logic       clk;
  logic       reset;
  logic       data_i;
  logic [6:0] data_o;
  logic       valid_o;
  logic       locked_o;
  logic       err_o;

  oversampled_demodulator dut (
    .clk     (clk),
    .reset   (reset),
    .data_i  (data_i),
    .data_o  (data_o),
    .valid_o (valid_o),
    .locked_o(locked_o),
    .err_o   (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [6:0] word;
    int         at;    // cycle valid_o is due, or -1 when timing is not pinned
    bit         last;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [7:0]  sync;
    logic [27:0] words;
    int          per_a;
    int          per_b;
    bit          glitch;
    bit          exp_lock;
  } vec_t;

  // Monitor: pops the scoreboard on each valid_o and polices err_o.
  bit mon_en       = 1'b0;
  bit drop_pending = 1'b0;
  bit err_ok       = 1'b0;
  int err_seen     = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (drop_pending) begin
        check("locked_drop_after_frame", locked_o, 1'b0);
        drop_pending = 1'b0;
      end
      if (valid_o) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", valid_o, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("word_value", data_o, e.word);
          check("locked_at_valid", locked_o, 1'b1);
          if (e.at >= 0) check("word_latency", cyc, e.at);
          if (e.last) drop_pending = 1'b1;
        end
      end
      if (err_o) begin
        check("valid_with_err", valid_o, 1'b0);
        if (!err_ok) check("unexpected_err", err_o, 1'b0);
        else err_seen++;
      end
    end
  end

  // Called at a negedge; holds the bit for len cycles, optionally with a 1-cycle glitch.
  task automatic send_bit(input logic b, input int len, input bit glitch);
    data_i = b;
    if (glitch) begin
      repeat (6) @(negedge clk);
      data_i = ~b;
      @(negedge clk);
      data_i = b;
      repeat (len - 7) @(negedge clk);
    end else begin
      repeat (len) @(negedge clk);
    end
  endtask

  task automatic tx(input logic b, input vec_t v, inout int nb);
    int  len;
    bit  gl;
    len = (nb % 2 == 1) ? v.per_b : v.per_a;
    gl  = v.glitch && (nb % 3 == 2);
    nb++;
    send_bit(b, len, gl);
  endtask

  // Idle bits, sync word, then word_bits bits of the frame; trailing idle if tail is set.
  task automatic run_frame(input vec_t v, input int word_bits, input bit tail);
    int         nb;
    int         sent;
    bit         pinned;
    logic [6:0] w;
    exp_t       e;
    nb     = 0;
    sent   = 0;
    pinned = (v.per_a == OSR) && (v.per_b == OSR) && !v.glitch;
    for (int i = 0; i < 3; i++) tx(1'b0, v, nb);
    for (int i = 7; i >= 0; i--) tx(v.sync[i], v, nb);
    for (int wi = 0; wi < 4; wi++) begin
      w = v.words[27 - 7 * wi -: 7];
      for (int b = 6; b >= 0; b--) begin
        if (sent < word_bits) begin
          if (wi == 0 && b == 4) check("locked_after_sync", locked_o, v.exp_lock);
          if (b == 0 && v.exp_lock) begin
            e.word = w;
            e.at   = pinned ? cyc + 1 + OSR / 2 + 4 : -1;
            e.last = (wi == 3);
            sb.push_back(e);
          end
          tx(w[b], v, nb);
          sent++;
        end
      end
    end
    if (tail) for (int i = 0; i < 3; i++) tx(1'b0, v, nb);
  endtask

  vec_t vecs[5];
  vec_t tv;

  initial begin
    vecs[0] = '{sync: 8'hE4, words: {7'h55, 7'h2A, 7'h7F, 7'h01}, per_a: 8, per_b: 8,
                glitch: 1'b0, exp_lock: 1'b1};
    vecs[1] = '{sync: 8'hE5, words: {7'h55, 7'h2A, 7'h7F, 7'h01}, per_a: 8, per_b: 8,
                glitch: 1'b0, exp_lock: 1'b0};
    vecs[2] = '{sync: 8'hE4, words: {7'h55, 7'h2A, 7'h7F, 7'h01}, per_a: 7, per_b: 9,
                glitch: 1'b0, exp_lock: 1'b1};
    vecs[3] = '{sync: 8'hE4, words: {7'h55, 7'h2A, 7'h7F, 7'h01}, per_a: 8, per_b: 8,
                glitch: 1'b1, exp_lock: 1'b1};
    vecs[4] = '{sync: 8'hE4, words: {7'h00, 7'h7F, 7'h12, 7'h6C}, per_a: 8, per_b: 8,
                glitch: 1'b0, exp_lock: 1'b1};

    // Held in reset while the line toggles: every output stays low.
    reset  = 1'b0;
    data_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      data_i = ~data_i;
      check("reset_outputs", {data_o, valid_o, locked_o, err_o}, 32'd0);
    end
    @(negedge clk);
    data_i = 1'b0;
    reset  = 1'b1;
    repeat (4) @(negedge clk);
    mon_en = 1'b1;

    foreach (vecs[r]) begin
      check("locked_before_frame", locked_o, 1'b0);
      run_frame(vecs[r], 28, 1'b1);
      check("locked_after_frame", locked_o, 1'b0);
      check("scoreboard_drained", sb.size(), 0);
    end

    // Locked, then a silent line: two all-zero words, then one run-limit error.
    tv        = vecs[0];
    err_seen  = 0;
    err_ok    = 1'b1;
    run_frame(tv, 0, 1'b0);
    for (int i = 0; i < 2; i++) sb.push_back('{word: 7'h00, at: -1, last: 1'b0});
    data_i = 1'b0;
    repeat (200) @(negedge clk);
    err_ok = 1'b0;
    check("timeout_err_count", err_seen, 1);
    check("timeout_unlocked", locked_o, 1'b0);
    check("timeout_words_drained", sb.size(), 0);

    // Reset in the middle of the third word, then a clean frame.
    run_frame(vecs[0], 17, 1'b0);
    #2 reset = 1'b0;
    #1 check("reset_mid_outputs", {data_o, valid_o, locked_o, err_o}, 32'd0);
    check("reset_mid_no_pending", sb.size(), 0);
    drop_pending = 1'b0;
    repeat (3) @(negedge clk);
    data_i = 1'b0;
    reset  = 1'b1;
    repeat (4) @(negedge clk);
    run_frame(vecs[0], 28, 1'b1);
    check("reframe_unlocked", locked_o, 1'b0);
    check("reframe_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
